// File: rtl/vending_ctrl_multi.sv
// Vending controller: slot stock/price table, coin credit,
// one-hot selection with confirm, vend, change and refund.
module vending_ctrl_multi #(
   parameter int NUM_ITEMS = 6,
   parameter int COUNT_W   = 4,
   parameter int PRICE_W   = 8,
   parameter int ITEM_W    = $clog2(NUM_ITEMS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   input  logic [ITEM_W-1:0]    cfg_item,
   input  logic [COUNT_W-1:0]   cfg_count,
   input  logic [PRICE_W-1:0]   cfg_cost,
   output logic                 cfg_ready,
   input  logic                 coin_valid,
   input  logic [1:0]           coin,
   output logic                 coin_reject,
   input  logic [NUM_ITEMS-1:0] button,
   input  logic                 enter,
   input  logic                 cancel,
   output logic [PRICE_W-1:0]   credit,
   output logic [1:0]           status,
   output logic                 product_valid,
   output logic [ITEM_W-1:0]    product,
   output logic                 change_valid,
   output logic [PRICE_W-1:0]   change,
   output logic [NUM_ITEMS-1:0] sold_out
);

   typedef enum logic [2:0] {
      IDLE, CREDIT, SELECT, VEND, CHANGE
   } state_t;

   state_t              state;
   logic [ITEM_W-1:0]   sel;
   logic [COUNT_W-1:0]  stock [NUM_ITEMS];
   logic [PRICE_W-1:0]  cost  [NUM_ITEMS];
   logic [PRICE_W-1:0]  coin_val;
   logic [PRICE_W:0]    sum;
   logic                btn_any;
   logic                btn_one;
   logic [ITEM_W-1:0]   btn_idx;

   // coin denomination decode
   always_comb begin
      coin_val = PRICE_W'(1);
      unique case (coin)
         2'b00: coin_val = PRICE_W'(1);
         2'b01: coin_val = PRICE_W'(5);
         2'b10: coin_val = PRICE_W'(10);
         2'b11: coin_val = PRICE_W'(25);
      endcase
   end

   assign sum = {1'b0, credit} + {1'b0, coin_val};

   // button press classification and slot index
   always_comb begin
      btn_any = |button;
      btn_one = ($countones(button) == 1);
      btn_idx = '0;
      for (int i = 0; i < NUM_ITEMS; i++)
         if (button[i]) btn_idx = ITEM_W'(i);
   end

   // empty-slot flags follow the stock table
   always_comb begin
      sold_out = '0;
      for (int i = 0; i < NUM_ITEMS; i++)
         sold_out[i] = (stock[i] == '0);
   end

   // controller state, table and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         sel           <= '0;
         credit        <= '0;
         status        <= 2'b00;
         cfg_ready     <= 1'b1;
         coin_reject   <= 1'b0;
         product_valid <= 1'b0;
         product       <= '0;
         change_valid  <= 1'b0;
         change        <= '0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock[i] <= '0;
            cost[i]  <= '0;
         end
      end else begin
         coin_reject   <= 1'b0;
         product_valid <= 1'b0;
         product       <= '0;
         change_valid  <= 1'b0;
         change        <= '0;
         cfg_ready     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg_valid && cfg_item < ITEM_W'(NUM_ITEMS)) begin
                  stock[cfg_item] <= cfg_count;
                  cost[cfg_item]  <= cfg_cost;
               end
               if (coin_valid) begin
                  credit <= coin_val;
                  state  <= CREDIT;
               end else begin
                  cfg_ready <= 1'b1;
               end
            end
            CREDIT, SELECT: begin
               if (cancel) begin
                  coin_reject  <= coin_valid;
                  change_valid <= (credit != '0);
                  change       <= credit;
                  credit       <= '0;
                  state        <= CHANGE;
               end else if (enter && state == SELECT) begin
                  coin_reject <= coin_valid;
                  if (credit >= cost[sel]) begin
                     product_valid <= 1'b1;
                     product       <= sel + ITEM_W'(1);
                     credit        <= credit - cost[sel];
                     if (stock[sel] != '0)
                        stock[sel] <= stock[sel] - COUNT_W'(1);
                     status        <= 2'b00;
                     state         <= VEND;
                  end else begin
                     status <= 2'b10;
                  end
               end else if (btn_any) begin
                  coin_reject <= coin_valid;
                  if (!btn_one) begin
                     status <= 2'b11;
                  end else if (stock[btn_idx] == '0) begin
                     status <= 2'b01;
                  end else begin
                     sel    <= btn_idx;
                     status <= 2'b00;
                     state  <= SELECT;
                  end
               end else if (coin_valid) begin
                  if (!sum[PRICE_W])
                     credit <= sum[PRICE_W-1:0];
                  else
                     coin_reject <= 1'b1;
               end
            end
            VEND: begin
               coin_reject  <= coin_valid;
               change_valid <= (credit != '0);
               change       <= credit;
               credit       <= '0;
               state        <= CHANGE;
            end
            CHANGE: begin
               coin_reject <= coin_valid;
               status      <= 2'b00;
               cfg_ready   <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
